// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: in-order queue with a registered
// read port, occupancy/flag outputs and a sticky overflow flag.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned AFULL_LEVEL = 12
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic                  clr_overflow,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  afull,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FullCnt  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AfullCnt = (DEPTH_LOG2 + 1)'(AFULL_LEVEL);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_acc, wr_acc, ovf_evt;

    // Accept decisions; a full FIFO still takes a write when a read frees a slot.
    always_comb begin
        rd_acc  = rd_en & ~empty_q & ~flush;
        wr_acc  = wr_en & (~full_q | rd_acc) & ~flush;
        ovf_evt = wr_en & full_q & ~rd_acc & ~flush;
    end

    // Next-state: pointers, occupancy, flags (derived from next count so they never lag).
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        if (flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + 1'b1;
            if (rd_acc) begin
                rptr_d     = rptr_q + 1'b1;
                rd_data_d  = mem_q[rptr_q];
                rd_valid_d = 1'b1;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // A new overflow wins over a simultaneous clear.
            if (ovf_evt)           overflow_d = 1'b1;
            else if (clr_overflow) overflow_d = 1'b0;
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == FullCnt);
        afull_d = (count_d >= AfullCnt);
    end

    // Storage array; contents need no reset since pointers/count define validity.
    always_ff @(posedge CLK) begin
        if (wr_acc) mem_q[wptr_q] <= wr_data;
    end

    // Control and output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign afull    = afull_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
